// File: rtl/gtech_rep3_pkg.sv
// Shared definitions for the triple-repetition link (transmitter and receiver).
package gtech_rep3_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_GAP
    } state_t;

    localparam int REP = 3;
    localparam int CHIP_W = 2;
    localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(REP - 1);
    localparam logic START_SYM = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/gtech_rep3_chip_ctr.sv
// Chip position within a symbol (0..REP-1); flags the last chip and the
// upcoming middle chip, which is the only one fault injection may corrupt.
module gtech_rep3_chip_ctr
    import gtech_rep3_pkg::*;
(
    input  logic clk_sys,
    input  logic rst_n,
    input  logic run,
    output logic sym_done,
    output logic mid_next
);

    logic [CHIP_W-1:0] chip_q, chip_d;

    always_comb begin
        chip_d = '0;
        if (run) begin
            chip_d = (chip_q == CHIP_LAST) ? '0 : chip_q + CHIP_W'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            chip_q <= '0;
        end else begin
            chip_q <= chip_d;
        end
    end

    assign sym_done = run && (chip_q == CHIP_LAST);
    assign mid_next = run && (chip_q == '0);

endmodule

// File: rtl/gtech_rep3_tx.sv
// Triple-repetition serial transmitter: start, DATA_W bits LSB first and even
// parity, each sent as three equal chips, followed by GAP idle cycles.
//
// state   | meaning
// S_IDLE  | ready for a word, line at 0
// S_START | three start chips
// S_DATA  | three chips per data bit, LSB first
// S_PAR   | three parity chips
// S_GAP   | line held at 0 before returning to idle
module gtech_rep3_tx
    import gtech_rep3_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  logic              CP,
    input  logic              CD,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    input  logic              INJ,
    output logic              TX,
    output logic              TX_EN,
    output logic              BUSY
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_nxt;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              tx_en_q, tx_en_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              run, sym_done, mid_next, inj_bit;

    assign run       = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_PAR);
    assign inj_bit   = INJ & mid_next;
    assign shift_nxt = shift_q >> 1;

    gtech_rep3_chip_ctr u_chip_ctr (
        .clk_sys  (CP),
        .rst_n    (CD),
        .run      (run),
        .sym_done (sym_done),
        .mid_next (mid_next)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        par_d   = par_q;
        tx_d    = 1'b0;
        tx_en_d = tx_en_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                tx_en_d = 1'b0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                // Accept only against the registered ready so reset release costs one edge.
                if (DIN_VALID && ready_q) begin
                    state_d = S_START;
                    shift_d = DIN;
                    par_d   = ^DIN;
                    tx_d    = START_SYM;
                    tx_en_d = 1'b1;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (sym_done) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    tx_d = START_SYM ^ inj_bit;
                end
            end
            S_DATA: begin
                if (sym_done) begin
                    shift_d = shift_nxt;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_PAR;
                        tx_d    = par_q;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        tx_d  = shift_nxt[0];
                    end
                end else begin
                    tx_d = shift_q[0] ^ inj_bit;
                end
            end
            S_PAR: begin
                if (sym_done) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    tx_en_d = 1'b0;
                end else begin
                    tx_d = par_q ^ inj_bit;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_en_d = 1'b0;
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b0;
            tx_en_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            tx_en_q <= tx_en_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign TX        = tx_q;
    assign TX_EN     = tx_en_q;
    assign DIN_READY = ready_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_gtech_rep3_tx.sv
// Directed bench for gtech_rep3_tx: frame chip patterns, handshake timing,
// fault injection, mid-frame reset and valid-while-busy.
module tb_gtech_rep3_tx;

    logic       CP = 1'b0;
    logic       CD = 1'b0;
    logic [7:0] DIN = '0;
    logic       DIN_VALID = 1'b0;
    logic       DIN_READY;
    logic       INJ = 1'b0;
    logic       TX;
    logic       TX_EN;
    logic       BUSY;

    int n_checks = 0;
    int n_errors = 0;

    gtech_rep3_tx #(.DATA_W(8), .GAP(2)) dut (
        .CP        (CP),
        .CD        (CD),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .DIN_READY (DIN_READY),
        .INJ       (INJ),
        .TX        (TX),
        .TX_EN     (TX_EN),
        .BUSY      (BUSY)
    );

    always #5 CP = ~CP;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Chip string -> vector, chip j at bit j; spaces are separators only.
    function automatic logic [31:0] s2v(input string s);
        logic [31:0] v;
        int k;
        v = '0;
        k = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (s.getc(i) != 8'h20 && k < 32) begin
                v[k] = (s.getc(i) == 8'h31);
                k++;
            end
        end
        return v;
    endfunction

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Sends one word and records the 32 line cycles starting at the accept edge.
    task automatic send_frame(input logic [7:0] d, input logic inj, input logic hold,
                              input logic poke, input string tag,
                              output logic [31:0] cap, output int en_cnt, output int waited);
        @(negedge CP);
        DIN       = d;
        DIN_VALID = 1'b1;
        INJ       = inj;
        waited    = 0;
        while (!DIN_READY && waited < 50) begin
            @(negedge CP);
            waited++;
        end
        if (waited >= 50) chk({tag, "_accept_timeout"}, {31'b0, DIN_READY}, 32'd1);
        @(posedge CP);
        #1;
        if (!hold) DIN_VALID = 1'b0;
        DIN    = ~d;
        en_cnt = 0;
        cap    = '0;
        for (int j = 0; j < 32; j++) begin
            cap[j] = TX;
            if (TX_EN) en_cnt++;
            if (j == 0) begin
                chk({tag, "_busy_e0"}, {31'b0, BUSY}, 32'd1);
                chk({tag, "_ready_e0"}, {31'b0, DIN_READY}, 32'd0);
            end
            if (j == 31) chk({tag, "_ready_early"}, {31'b0, DIN_READY}, 32'd0);
            if (poke) begin
                if (j == 10) begin
                    DIN_VALID = 1'b1;
                    DIN       = 8'hFF;
                end
                if (j == 12) DIN = 8'h00;
                if (j == 14) DIN_VALID = 1'b0;
            end
            @(posedge CP);
            #1;
        end
        chk({tag, "_ready_e33"}, {31'b0, DIN_READY}, 32'd1);
        chk({tag, "_busy_e33"}, {31'b0, BUSY}, 32'd0);
        chk({tag, "_tx_en_cnt"}, en_cnt, 32'd30);
    endtask

    logic [31:0] cap;
    int          en_cnt;
    int          waited;
    logic [7:0]  dec;
    logic        dec_par;
    logic        dec_start;

    initial begin
        // Reset held while clocking
        repeat (3) @(posedge CP);
        #1;
        chk("rst_tx", {31'b0, TX}, 32'd0);
        chk("rst_tx_en", {31'b0, TX_EN}, 32'd0);
        chk("rst_busy", {31'b0, BUSY}, 32'd0);
        chk("rst_ready", {31'b0, DIN_READY}, 32'd0);
        @(negedge CP);
        CD = 1'b1;
        #1;
        chk("ready_before_edge", {31'b0, DIN_READY}, 32'd0);
        @(posedge CP);
        #1;
        chk("ready_first_edge", {31'b0, DIN_READY}, 32'd1);
        chk("busy_first_edge", {31'b0, BUSY}, 32'd0);

        // 0xA5, parity 0
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, "a5", cap, en_cnt, waited);
        chk("a5_tx", cap, s2v("111 111 000 111 000 000 111 000 111 000 00"));

        // Back-to-back 0x00 then 0x01 with valid held
        send_frame(8'h00, 1'b0, 1'b1, 1'b0, "b2b0", cap, en_cnt, waited);
        chk("b2b0_tx", cap, s2v("111 000 000 000 000 000 000 000 000 000 00"));
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, "b2b1", cap, en_cnt, waited);
        chk("b2b1_wait", waited, 32'd0);
        chk("b2b1_tx", cap, s2v("111 111 000 000 000 000 000 000 000 111 00"));

        // Middle-chip fault injection over the whole frame
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, "inj", cap, en_cnt, waited);
        INJ = 1'b0;
        chk("inj_tx", cap, s2v("101 101 010 010 010 010 010 010 010 101 00"));
        dec_start = maj(cap[0], cap[1], cap[2]);
        for (int s = 0; s < 8; s++) dec[s] = maj(cap[3*s+3], cap[3*s+4], cap[3*s+5]);
        dec_par = maj(cap[27], cap[28], cap[29]);
        chk("inj_vote_start", {31'b0, dec_start}, 32'd1);
        chk("inj_vote_data", {24'b0, dec}, 32'h01);
        chk("inj_vote_par", {31'b0, dec_par}, {31'b0, ^8'h01});

        // Valid and DIN toggled mid-frame must not disturb the frame
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, "busy_poke", cap, en_cnt, waited);
        chk("busy_poke_tx", cap, s2v("111 111 000 111 000 000 111 000 111 000 00"));

        // Reset during data bit 3 of 0xFF
        @(negedge CP);
        DIN       = 8'hFF;
        DIN_VALID = 1'b1;
        @(posedge CP);
        #1;
        DIN_VALID = 1'b0;
        repeat (13) @(posedge CP);
        #1;
        chk("mid_tx_bit3", {31'b0, TX}, 32'd1);
        chk("mid_busy", {31'b0, BUSY}, 32'd1);
        #2;
        CD = 1'b0;
        #1;
        chk("abort_tx", {31'b0, TX}, 32'd0);
        chk("abort_tx_en", {31'b0, TX_EN}, 32'd0);
        chk("abort_busy", {31'b0, BUSY}, 32'd0);
        chk("abort_ready", {31'b0, DIN_READY}, 32'd0);
        repeat (2) @(posedge CP);
        @(negedge CP);
        CD = 1'b1;

        // Clean frame after abort: 0x3C, parity 0
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, "post_rst", cap, en_cnt, waited);
        chk("post_rst_tx", cap, s2v("111 000 000 111 111 111 111 000 000 000 00"));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
